// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done handshake and operand/result bundle for serial_sub
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, Diff, Borrow, Ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, Diff, Borrow, Ovf
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - digit-serial subtractor a - b - bin, DIGIT bits per clock
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  logic [DIGIT:0]   d;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  // One DIGIT-wide subtract cell; the extra top bit of d is the borrow-out.
  always_comb begin
    d        = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    res_next = res_sh >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = d[DIGIT-1:0];
    a_next   = a_sh >> DIGIT;
    b_next   = b_sh >> DIGIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.bin;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            res_sh <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_next;
          b_sh   <= b_next;
          res_sh <= res_next;
          borrow <= d[DIGIT];
          if (cnt == CNT_LAST) begin
            // Outputs only move here, so partial results never escape.
            diff_q   <= res_next;
            borrow_q <= d[DIGIT];
            ovf_q    <= (a_msb ^ b_msb) & (res_next[WIDTH-1] ^ a_msb);
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;
  assign bus.Ovf    = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - randomized self-checking bench for serial_sub (DIGIT=1 and DIGIT=4)
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) if1 ();
  serial_sub_if #(.WIDTH(8)) if4 ();

  logic       start1 = 1'b0;
  logic       start4 = 1'b0;
  logic [7:0] a_in   = 8'h00;
  logic [7:0] b_in   = 8'h00;
  logic       bin_in = 1'b0;

  assign if1.start = start1;
  assign if1.a     = a_in;
  assign if1.b     = b_in;
  assign if1.bin   = bin_in;
  assign if4.start = start4;
  assign if4.a     = a_in;
  assign if4.b     = b_in;
  assign if4.bin   = bin_in;

  serial_sub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_checks = 0;
  int n_fail   = 0;
  bit sel      = 1'b0;

  logic       o_busy, o_done, o_borrow, o_ovf;
  logic [7:0] o_diff;
  always_comb begin
    if (sel) begin
      o_busy = if4.busy; o_done = if4.done; o_diff = if4.Diff; o_borrow = if4.Borrow; o_ovf = if4.Ovf;
    end else begin
      o_busy = if1.busy; o_done = if1.done; o_diff = if1.Diff; o_borrow = if1.Borrow; o_ovf = if1.Ovf;
    end
  end

  int         r_lat;
  bit         r_timeout, r_busy_ok, r_post_busy, r_post_done;
  logic [9:0] r_res;

  function automatic int n_of(input bit s);
    return s ? 2 : 8;
  endfunction

  // Reference: {Borrow, Ovf, Diff} from unsigned arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int         full;
    logic [7:0] dif;
    logic       brw, ovf;
    full = int'(a) - int'(b) - int'(bi);
    dif  = 8'(full & 255);
    brw  = (int'(a) < int'(b) + int'(bi));
    ovf  = (a[7] != b[7]) && (dif[7] != a[7]);
    return {brw, ovf, dif};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    a_in = a; b_in = b; bin_in = bi;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
    r_timeout = 1'b1; r_busy_ok = 1'b1; r_lat = -1; r_res = '0;
    for (int c = 0; c < 20; c++) begin
      if (!o_busy) r_busy_ok = 1'b0;
      if (o_done) begin
        r_lat = c; r_timeout = 1'b0; r_res = {o_borrow, o_ovf, o_diff};
        break;
      end
      tick();
    end
    tick();
    r_post_busy = o_busy;
    r_post_done = o_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      n_checks++;
      if ({o_busy, o_done, o_borrow, o_ovf, o_diff} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got busy=%b done=%b diff=%h brw=%b ovf=%b want all 0",
                 s ? 4 : 1, o_busy, o_done, o_diff, o_borrow, o_ovf);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'hA5};
    logic [7:0] tb_[5] = '{8'h03, 8'h05, 8'h01, 8'h00, 8'h5A};
    logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] te [5] = '{{2'b00, 8'h02}, {2'b10, 8'hFE}, {2'b01, 8'h7F}, {2'b10, 8'hFF}, {2'b01, 8'h4B}};
    for (int i = 0; i < 5; i++) begin
      sel = (i == 4);
      do_op(ta[i], tb_[i], tc[i]);
      n_checks++;
      if (r_timeout || r_res !== te[i]) begin
        n_fail++;
        $display("FAIL directed_%0d result got {brw,ovf,diff}=%h timeout=%b want %h", i, r_res, r_timeout, te[i]);
      end
      n_checks++;
      if (r_lat != n_of(sel) || !r_busy_ok || r_post_busy || r_post_done) begin
        n_fail++;
        $display("FAIL directed_%0d timing got lat=%0d busy_ok=%b post_busy=%b post_done=%b want lat=%0d,1,0,0",
                 i, r_lat, r_busy_ok, r_post_busy, r_post_done, n_of(sel));
      end
    end
  endtask

  task automatic test_hold();
    logic [9:0] exp;
    sel = 1'b0;
    exp = model(8'h00, 8'h00, 1'b1);
    do_op(8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({o_borrow, o_ovf, o_diff} !== exp || o_busy || o_done) begin
        n_fail++;
        $display("FAIL hold_idle_%0d got %h busy=%b done=%b want %h,0,0", i, {o_borrow, o_ovf, o_diff}, o_busy, o_done, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       bi;
    logic [9:0] exp;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 25; i++) begin
        a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
        if (i == 0) begin a = 8'hFF; b = 8'hFF; bi = 1'b1; end
        if (i == 1) begin a = 8'h7F; b = 8'h80; bi = 1'b0; end
        exp = model(a, b, bi);
        do_op(a, b, bi);
        n_checks++;
        if (r_timeout || r_res !== exp || r_lat != n_of(sel)) begin
          n_fail++;
          $display("FAIL random_dut%0d a=%h b=%h bin=%b got %h lat=%0d want %h lat=%0d",
                   s ? 4 : 1, a, b, bi, r_res, r_lat, exp, n_of(sel));
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] a, b;
    logic [9:0] exp;
    int         dones;
    sel = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    exp = model(a, b, 1'b0);
    a_in = a; b_in = b; bin_in = 1'b0;
    set_start(1'b1); tick(); set_start(1'b0);
    tick(); tick();
    a_in = ~a; b_in = ~b; bin_in = 1'b1;
    set_start(1'b1); tick(); set_start(1'b0);
    dones = 0;
    r_res = '0;
    for (int c = 0; c < 20; c++) begin
      if (o_done) begin
        dones++;
        r_res = {o_borrow, o_ovf, o_diff};
      end
      tick();
    end
    n_checks++;
    if (dones != 1 || r_res !== exp) begin
      n_fail++;
      $display("FAIL start_while_busy got dones=%0d res=%h want dones=1 res=%h", dones, r_res, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [9:0] exp;
    int         last, cnt, want_cnt, n;
    bit         ok;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      n = n_of(sel);
      a = 8'($urandom); b = 8'($urandom);
      exp = model(a, b, 1'b1);
      a_in = a; b_in = b; bin_in = 1'b1;
      set_start(1'b1);
      tick();
      last = -1; cnt = 0; ok = 1'b1;
      for (int t = 0; t < 30; t++) begin
        if (o_done) begin
          if ({o_borrow, o_ovf, o_diff} !== exp) ok = 1'b0;
          if (last < 0 ? (t != n) : (t - last != n + 2)) ok = 1'b0;
          last = t;
          cnt++;
        end
        tick();
      end
      set_start(1'b0);
      want_cnt = 0;
      for (int t = n; t < 30; t += n + 2) want_cnt++;
      n_checks++;
      if (!ok || cnt != want_cnt) begin
        n_fail++;
        $display("FAIL back_to_back_dut%0d got ok=%b dones=%0d want ok=1 dones=%0d", s ? 4 : 1, ok, cnt, want_cnt);
      end
      for (int t = 0; t < n + 4; t++) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp;
    bit         saw;
    sel = 1'b0;
    do_op(8'h03, 8'h05, 1'b0);
    a_in = 8'h5C; b_in = 8'h21; bin_in = 1'b0;
    set_start(1'b1); tick(); set_start(1'b0);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if ({o_busy, o_done, o_borrow, o_ovf, o_diff} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_run got busy=%b done=%b diff=%h brw=%b ovf=%b want all 0",
               o_busy, o_done, o_diff, o_borrow, o_ovf);
    end
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin if (o_done || o_busy) saw = 1'b1; tick(); end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got activity=1 want 0");
    end
    rst = 1'b1; set_start(1'b1); tick(); rst = 1'b0; set_start(1'b0);
    saw = o_busy;
    for (int c = 0; c < 12; c++) begin if (o_done || o_busy) saw = 1'b1; tick(); end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL reset_with_start got activity=1 want stay idle");
    end
    exp = model(8'h5C, 8'h21, 1'b1);
    do_op(8'h5C, 8'h21, 1'b1);
    n_checks++;
    if (r_timeout || r_res !== exp || r_lat != 8) begin
      n_fail++;
      $display("FAIL after_reset_op got %h lat=%0d want %h lat=8", r_res, r_lat, exp);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
